ex_hazard_ctrl: RTL and testbench

- Execute-stage forwarding and hazard controller.
- Drives the opA/opB/opSr forwarding-mux selects of the execute stage.
- Detects load-use hazards and inserts exactly one bubble into MEM while freezing IF/ID/EX.
- Tracks MEM/WB slot validity internally so bubbles and killed packets never forward.

---
 rtl/ex_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage forwarding select and load-use hazard controller with MEM/WB shadow tracking.
// Optional event counters (lu_stall_cnt, fwd_cnt) are built when EX_HAZARD_STATS_EN is defined.
module ex_hazard_ctrl #(
  parameter int unsigned REGIDX_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [REGIDX_W-1:0] ex_sr1,
  input  logic [REGIDX_W-1:0] ex_sr2,
  input  logic                ex_uses_sr1,
  input  logic                ex_uses_sr2,
  input  logic                ex_alumux_sel,
  input  logic                ex_is_store,
  input  logic [REGIDX_W-1:0] ex_dest,
  input  logic                ex_ld_regfile,
  input  logic                ex_is_load,
  input  logic                mem_stall,
  input  logic                pip_flush,
  output logic [1:0]          opAmux_sel,
  output logic [1:0]          opBmux_sel,
  output logic [1:0]          opSrmux_sel,
  output logic                stall_front,
  output logic                mem_bubble,
`ifdef EX_HAZARD_STATS_EN
  output logic [15:0]         lu_stall_cnt,
  output logic [15:0]         fwd_cnt,
`endif
  output logic                lu_active
);

  typedef enum logic [0:0] {StRun, StLuStall} state_e;

  state_e              state_q, state_d;
  logic                mem_v_q, mem_v_d;
  logic [REGIDX_W-1:0] mem_dest_q, mem_dest_d;
  logic                mem_ld_q, mem_ld_d;
  logic                mem_isld_q, mem_isld_d;
  logic                wb_v_q, wb_v_d;
  logic [REGIDX_W-1:0] wb_dest_q, wb_dest_d;
  logic                wb_ld_q, wb_ld_d;

  logic need_a, need_b, need_sr;
  logic mem_fwd_ok, mem_load_ok, wb_fwd_ok;
  logic hazard;

  // Branch flushes are resolved upstream; the EX packet is tracked unchanged.
  logic unused_pip_flush;
  assign unused_pip_flush = pip_flush;

  function automatic logic [1:0] fwd_sel(input logic                need,
                                         input logic [REGIDX_W-1:0] idx,
                                         input logic                mem_ok,
                                         input logic [REGIDX_W-1:0] mem_idx,
                                         input logic                wb_ok,
                                         input logic [REGIDX_W-1:0] wb_idx);
    logic [1:0] sel;
    sel = 2'b00;
    if (need && mem_ok && (idx == mem_idx)) begin
      sel = 2'b01;
    end else if (need && wb_ok && (idx == wb_idx)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    need_a      = ex_valid & ex_uses_sr1;
    need_b      = ex_valid & ex_uses_sr2 & ~ex_alumux_sel;
    need_sr     = ex_valid & ex_is_store;
    // A load in MEM has no data yet, so it can only cause a stall, never a forward.
    mem_fwd_ok  = mem_v_q & mem_ld_q & ~mem_isld_q;
    mem_load_ok = mem_v_q & mem_ld_q & mem_isld_q;
    wb_fwd_ok   = wb_v_q & wb_ld_q;

    opAmux_sel  = fwd_sel(need_a, ex_sr1, mem_fwd_ok, mem_dest_q, wb_fwd_ok, wb_dest_q);
    opBmux_sel  = fwd_sel(need_b, ex_sr2, mem_fwd_ok, mem_dest_q, wb_fwd_ok, wb_dest_q);
    opSrmux_sel = fwd_sel(need_sr, ex_sr2, mem_fwd_ok, mem_dest_q, wb_fwd_ok, wb_dest_q);

    hazard = mem_load_ok & ((need_a & (ex_sr1 == mem_dest_q)) |
                            ((need_b | need_sr) & (ex_sr2 == mem_dest_q)));

    stall_front = (state_q == StRun) & hazard;
    mem_bubble  = stall_front;
    lu_active   = (state_q == StLuStall);
  end

  always_comb begin
    state_d    = state_q;
    mem_v_d    = mem_v_q;
    mem_dest_d = mem_dest_q;
    mem_ld_d   = mem_ld_q;
    mem_isld_d = mem_isld_q;
    wb_v_d     = wb_v_q;
    wb_dest_d  = wb_dest_q;
    wb_ld_d    = wb_ld_q;

    if (!mem_stall) begin
      wb_v_d    = mem_v_q;
      wb_dest_d = mem_dest_q;
      wb_ld_d   = mem_ld_q;
      if (stall_front) begin
        mem_v_d    = 1'b0;
        mem_dest_d = '0;
        mem_ld_d   = 1'b0;
        mem_isld_d = 1'b0;
      end else begin
        mem_v_d    = ex_valid;
        mem_dest_d = ex_dest;
        mem_ld_d   = ex_ld_regfile;
        mem_isld_d = ex_is_load;
      end

      unique case (state_q)
        StRun:     if (hazard) state_d = StLuStall;
        StLuStall: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

`ifdef EX_HAZARD_STATS_EN
  logic [15:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    lu_stall_cnt_d = lu_stall_cnt_q;
    fwd_cnt_d      = fwd_cnt_q;
    if (!mem_stall) begin
      if (stall_front && (lu_stall_cnt_q != 16'hFFFF)) lu_stall_cnt_d = lu_stall_cnt_q + 16'd1;
      if (((opAmux_sel | opBmux_sel | opSrmux_sel) != 2'b00) && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_d = fwd_cnt_q + 16'd1;
      end
    end
  end

  assign lu_stall_cnt = lu_stall_cnt_q;
  assign fwd_cnt      = fwd_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      mem_v_q    <= 1'b0;
      mem_dest_q <= '0;
      mem_ld_q   <= 1'b0;
      mem_isld_q <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_dest_q  <= '0;
      wb_ld_q    <= 1'b0;
`ifdef EX_HAZARD_STATS_EN
      lu_stall_cnt_q <= '0;
      fwd_cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_v_q    <= mem_v_d;
      mem_dest_q <= mem_dest_d;
      mem_ld_q   <= mem_ld_d;
      mem_isld_q <= mem_isld_d;
      wb_v_q     <= wb_v_d;
      wb_dest_q  <= wb_dest_d;
      wb_ld_q    <= wb_ld_d;
`ifdef EX_HAZARD_STATS_EN
      lu_stall_cnt_q <= lu_stall_cnt_d;
      fwd_cnt_q      <= fwd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: in-flight-writer model checked every cycle plus directed literal checks.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, ex_valid, ex_uses_sr1, ex_uses_sr2, ex_alumux_sel, ex_is_store;
  logic [2:0] ex_sr1, ex_sr2, ex_dest;
  logic       ex_ld_regfile, ex_is_load, mem_stall, pip_flush;
  logic [1:0] opAmux_sel, opBmux_sel, opSrmux_sel;
  logic       stall_front, mem_bubble, lu_active;
`ifdef EX_HAZARD_STATS_EN
  logic [15:0] lu_stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.REGIDX_W(3)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2),
    .ex_uses_sr1(ex_uses_sr1), .ex_uses_sr2(ex_uses_sr2), .ex_alumux_sel(ex_alumux_sel),
    .ex_is_store(ex_is_store), .ex_dest(ex_dest), .ex_ld_regfile(ex_ld_regfile),
    .ex_is_load(ex_is_load), .mem_stall(mem_stall), .pip_flush(pip_flush),
    .opAmux_sel(opAmux_sel), .opBmux_sel(opBmux_sel), .opSrmux_sel(opSrmux_sel),
    .stall_front(stall_front), .mem_bubble(mem_bubble),
`ifdef EX_HAZARD_STATS_EN
    .lu_stall_cnt(lu_stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .lu_active(lu_active)
  );

  // Model: the instructions in flight after EX, youngest first (0 = MEM, 1 = WB).
  typedef struct packed {bit v; bit [2:0] dest; bit wr; bit load;} slot_t;
  slot_t       pipe [2];
  bit          m_lu;
  int unsigned m_lu_cnt, m_fwd_cnt;

  // Nearest in-flight writer of r supplies the value, except a load still in MEM.
  function automatic logic [1:0] m_sel(input bit need, input logic [2:0] r);
    if (!(need && ex_valid)) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].v && pipe[k].wr && pipe[k].dest == r) begin
        if (k == 0 && pipe[k].load) continue;
        return (k == 0) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit need_b;
    if (m_lu || !ex_valid) return 1'b0;
    if (!(pipe[0].v && pipe[0].wr && pipe[0].load)) return 1'b0;
    need_b = ex_uses_sr2 && !ex_alumux_sel;
    return (ex_uses_sr1 && ex_sr1 == pipe[0].dest) ||
           ((need_b || ex_is_store) && ex_sr2 == pipe[0].dest);
  endfunction

  function automatic bit m_any_fwd();
    return (m_sel(ex_uses_sr1, ex_sr1) | m_sel(ex_uses_sr2 && !ex_alumux_sel, ex_sr2) |
            m_sel(ex_is_store, ex_sr2)) != 2'b00;
  endfunction

  always @(posedge clk) begin : model
    bit st, fw;
    st = m_stall();
    fw = m_any_fwd();
    if (reset) begin
      pipe[0].v <= 1'b0;
      pipe[1].v <= 1'b0;
      m_lu      <= 1'b0;
      m_lu_cnt  <= 0;
      m_fwd_cnt <= 0;
    end else if (!mem_stall) begin
      pipe[1] <= pipe[0];
      pipe[0] <= st ? slot_t'(0) : '{v: ex_valid, dest: ex_dest, wr: ex_ld_regfile,
                                     load: ex_is_load};
      m_lu    <= st;
      if (st && m_lu_cnt < 65535) m_lu_cnt <= m_lu_cnt + 1;
      if (fw && m_fwd_cnt < 65535) m_fwd_cnt <= m_fwd_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_opA", 16'(opAmux_sel), 16'(m_sel(ex_uses_sr1, ex_sr1)));
      chk("m_opB", 16'(opBmux_sel), 16'(m_sel(ex_uses_sr2 && !ex_alumux_sel, ex_sr2)));
      chk("m_opSr", 16'(opSrmux_sel), 16'(m_sel(ex_is_store, ex_sr2)));
      chk("m_stall_front", 16'(stall_front), 16'(m_stall()));
      chk("m_mem_bubble", 16'(mem_bubble), 16'(m_stall()));
      chk("m_lu_active", 16'(lu_active), 16'(m_lu));
`ifdef EX_HAZARD_STATS_EN
      chk("m_lu_stall_cnt", lu_stall_cnt, 16'(m_lu_stall_cnt_sat()));
      chk("m_fwd_cnt", fwd_cnt, 16'(m_fwd_cnt));
`endif
    end
  end

  function automatic int unsigned m_lu_stall_cnt_sat();
    return m_lu_cnt;
  endfunction

  task automatic hold();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] d, input logic wr, input logic ld,
                     input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                     input logic u2, input logic amx, input logic st);
    hold();
    ex_valid = v; ex_dest = d; ex_ld_regfile = wr; ex_is_load = ld;
    ex_sr1 = s1; ex_uses_sr1 = u1; ex_sr2 = s2; ex_uses_sr2 = u2;
    ex_alumux_sel = amx; ex_is_store = st;
  endtask

  task automatic alu(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    put(1'b1, d, 1'b1, 1'b0, s1, 1'b1, s2, 1'b1, 1'b0, 1'b0);
  endtask

  // Immediate form: uses_sr2 left high so the alumux mask is exercised.
  task automatic alui(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    put(1'b1, d, 1'b1, 1'b0, s1, 1'b1, s2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic ldr(input logic [2:0] d, input logic [2:0] s1);
    put(1'b1, d, 1'b1, 1'b1, s1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic str(input logic [2:0] s1, input logic [2:0] s2);
    put(1'b1, 3'd0, 1'b0, 1'b0, s1, 1'b1, s2, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic kill();
    put(1'b0, 3'd1, 1'b1, 1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; mem_stall = 1'b0; pip_flush = 1'b0;
    ex_valid = 1'b0; ex_sr1 = '0; ex_sr2 = '0; ex_dest = '0; ex_uses_sr1 = 1'b0;
    ex_uses_sr2 = 1'b0; ex_alumux_sel = 1'b0; ex_is_store = 1'b0; ex_ld_regfile = 1'b0;
    ex_is_load = 1'b0;
    hold();
    check_en = 1'b1;

    // Reset state with a valid EX instruction reading R0
    alu(3'd0, 3'd0, 3'd0);
    #1;
    chk("rst_lu_active", 16'(lu_active), 16'd0);
    chk("rst_stall", 16'(stall_front), 16'd0);
    chk("rst_bubble", 16'(mem_bubble), 16'd0);
    chk("rst_opA", 16'(opAmux_sel), 16'd0);
    chk("rst_opB", 16'(opBmux_sel), 16'd0);

    // ADD R1 ; ADD R2,R1,R3
    alu(3'd1, 3'd2, 3'd3);
    reset = 1'b0;
    alu(3'd2, 3'd1, 3'd3);
    #1;
    chk("t1_opA", 16'(opAmux_sel), 16'd1);
    chk("t1_opB", 16'(opBmux_sel), 16'd0);
    chk("t1_stall", 16'(stall_front), 16'd0);

    // ADD R1 ; NOP ; ADD R4,R1,R1
    alu(3'd1, 3'd2, 3'd3);
    put(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    alu(3'd4, 3'd1, 3'd1);
    #1;
    chk("t2_opA", 16'(opAmux_sel), 16'd2);
    chk("t2_opB", 16'(opBmux_sel), 16'd2);

    // Invalid EX packet never forwards
    alu(3'd1, 3'd2, 3'd3);
    kill();
    #1;
    chk("t8_opA", 16'(opAmux_sel), 16'd0);
    chk("t8_opSr", 16'(opSrmux_sel), 16'd0);

    // LDR R5 ; ADD R6,R5,#imm
    ldr(3'd5, 3'd0);
    alui(3'd6, 3'd5, 3'd5);
    #1;
    chk("t3_stall", 16'(stall_front), 16'd1);
    chk("t3_bubble", 16'(mem_bubble), 16'd1);
    chk("t3_lu0", 16'(lu_active), 16'd0);
    hold();
    #1;
    chk("t3_stall_off", 16'(stall_front), 16'd0);
    chk("t3_opA", 16'(opAmux_sel), 16'd2);
    chk("t3_opB", 16'(opBmux_sel), 16'd0);
    chk("t3_lu1", 16'(lu_active), 16'd1);
    put(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t3_lu_end", 16'(lu_active), 16'd0);

    // LDR R5 ; STR R5 with a 3-cycle dcache stall during the hazard
    ldr(3'd5, 3'd0);
    str(3'd0, 3'd5);
    mem_stall = 1'b1;
    #1;
    chk("t4_stall_c0", 16'(stall_front), 16'd1);
    repeat (2) begin
      hold();
      #1;
      chk("t4_stall_ms", 16'(stall_front), 16'd1);
      chk("t4_lu_ms", 16'(lu_active), 16'd0);
    end
    hold();
    mem_stall = 1'b0;
    #1;
    chk("t4_stall_last", 16'(stall_front), 16'd1);
    chk("t4_bubble", 16'(mem_bubble), 16'd1);
    hold();
    #1;
    chk("t4_stall_off", 16'(stall_front), 16'd0);
    chk("t4_bubble_off", 16'(mem_bubble), 16'd0);
    chk("t4_opSr", 16'(opSrmux_sel), 16'd2);

    // MEM priority over WB, with pip_flush toggling around it
    pip_flush = 1'b1;
    alu(3'd1, 3'd2, 3'd3);
    alu(3'd1, 3'd2, 3'd3);
    pip_flush = 1'b0;
    alu(3'd7, 3'd1, 3'd2);
    #1;
    chk("t5_opA", 16'(opAmux_sel), 16'd1);

    // R0 is an ordinary register
    alu(3'd0, 3'd2, 3'd3);
    alu(3'd3, 3'd0, 3'd0);
    #1;
    chk("t7_opA", 16'(opAmux_sel), 16'd1);
    chk("t7_opB", 16'(opBmux_sel), 16'd1);

    // WB ALU and MEM load both write R3: stall, then forward the load from WB
    alu(3'd3, 3'd1, 3'd2);
    ldr(3'd3, 3'd0);
    alu(3'd0, 3'd3, 3'd3);
    #1;
    chk("t6_stall", 16'(stall_front), 16'd1);
    chk("t6_opA_stall", 16'(opAmux_sel), 16'd2);
    hold();
    #1;
    chk("t6_stall_off", 16'(stall_front), 16'd0);
    chk("t6_opA", 16'(opAmux_sel), 16'd2);
    chk("t6_opB", 16'(opBmux_sel), 16'd2);

    // Reset while in LU_STALL
    ldr(3'd5, 3'd0);
    alu(3'd6, 3'd5, 3'd0);
    hold();
    #1;
    chk("t9_lu_pre", 16'(lu_active), 16'd1);
    reset = 1'b1;
    hold();
    #1;
    chk("t9_lu", 16'(lu_active), 16'd0);
    chk("t9_opA", 16'(opAmux_sel), 16'd0);
    chk("t9_stall", 16'(stall_front), 16'd0);
`ifdef EX_HAZARD_STATS_EN
    chk("t9_cnt_rst", lu_stall_cnt, 16'd0);
`endif
    reset = 1'b0;
    ldr(3'd5, 3'd0);
    alu(3'd6, 3'd5, 3'd0);
    hold();
    hold();
`ifdef EX_HAZARD_STATS_EN
    #1;
    chk("t9_cnt_one", lu_stall_cnt, 16'd1);
`endif

    // Mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      put(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      mem_stall = ($urandom_range(0, 3) == 0);
      pip_flush = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 60) == 0);
    end
    reset = 1'b0;
    hold();
    hold();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
